sorted_region_checker: RTL and testbench

- Synthesizable successor to the bench-only sort check: scans a block of data-memory words after the CPU reaches a programmed end PC.
- Counts adjacent-order violations and mismatches against an expected-value ROM, then reports a pass/fail flag.
- Sits beside single_cycle_mips on a spare dmem read port. It is used in FPGA self-test and by all sort-program benches.
- Generalised in width, region size, base, order direction and signedness.

---
 rtl/mips_chk_pkg.sv | 28 ++
 rtl/sat_counter.sv | 34 +++
 rtl/sorted_region_checker.sv | 155 +++++++++++++++
 tb/tb_sorted_region_checker.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_chk_pkg.sv
// rtl/mips_chk_pkg.sv - shared types and compare helper for the sorted-region checker
package mips_chk_pkg;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

  localparam int ORDER_ASC    = 0;
  localparam int ORDER_DESC   = 1;
  localparam int CMP_UNSIGNED = 0;
  localparam int CMP_SIGNED   = 1;

  // Operands arrive already extended to 64 bits according to sgn.
  function automatic logic order_violation(input logic [63:0] prev,
                                           input logic [63:0] cur,
                                           input logic        desc,
                                           input logic        sgn);
    logic lt;
    logic gt;
    if (sgn) begin
      lt = $signed(prev) < $signed(cur);
      gt = $signed(prev) > $signed(cur);
    end else begin
      lt = prev < cur;
      gt = prev > cur;
    end
    return desc ? lt : gt;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/sorted_region_checker.sv
// rtl/sorted_region_checker.sv - scans a dmem region after end-PC, counts order and expected-value errors
module sorted_region_checker #(
  parameter int              DATA_W     = 32,
  parameter int              ADDR_W     = 10,
  parameter int              BASE_IDX   = 32,
  parameter int              COUNT      = 96,
  parameter int              ORDER_DESC = 1,
  parameter int              SIGNED_CMP = 0,
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] END_PC     = PC_W'(32'h78),
  parameter int              CNT_W      = 9
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [PC_W-1:0]                              pc,
  input  logic                                         start,
  output logic                                         mem_rd_en,
  output logic [ADDR_W-1:0]                            mem_rd_addr,
  input  logic [DATA_W-1:0]                            mem_rd_data,
  output logic [((COUNT > 1) ? $clog2(COUNT) : 1)-1:0] exp_rd_addr,
  input  logic [DATA_W-1:0]                            exp_rd_data,
  output logic                                         busy,
  output logic                                         done,
  output logic [CNT_W-1:0]                             err_unsorted,
  output logic [CNT_W-1:0]                             err_exp,
  output logic                                         pass
);

  import mips_chk_pkg::*;

  localparam int                EXP_W    = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [EXP_W-1:0]  LAST_IDX = EXP_W'(COUNT - 1);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_IDX);

  if ((COUNT < 1) || (DATA_W > 64) ||
      (longint'(BASE_IDX) + longint'(COUNT) - 1 >= (64'd1 << ADDR_W))) begin : g_bad_cfg
    $fatal(1, "sorted_region_checker: scanned region does not fit the address space");
  end

  state_e              state_q;
  logic                rd_en_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [EXP_W-1:0]    idx_q;
  logic                busy_q;
  logic                done_q;
  logic                pc_hit_q;
  logic                vld_q;
  logic                ord_q;
  logic [DATA_W-1:0]   prev_q;

  logic                pc_match;
  logic                trigger;
  logic                accept;
  logic [63:0]         prev_x;
  logic [63:0]         cur_x;
  logic                inc_ord;
  logic                inc_exp;

  // A level-held end PC fires only on its first cycle.
  assign pc_match = (pc == END_PC);
  assign trigger  = start | (pc_match & ~pc_hit_q);
  assign accept   = trigger && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pc_hit_q  <= 1'b0;
    end else begin
      pc_hit_q <= pc_match;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state_q   <= S_READ;
            rd_en_q   <= 1'b1;
            rd_addr_q <= BASE_A;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        S_READ: begin
          if (idx_q == LAST_IDX) begin
            state_q <= S_DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            idx_q     <= idx_q + EXP_W'(1);
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Compare stage trails issue by one cycle; the first word has no predecessor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= 1'b0;
      ord_q  <= 1'b0;
      prev_q <= '0;
    end else begin
      vld_q <= rd_en_q;
      ord_q <= rd_en_q && (idx_q != '0);
      if (vld_q) begin
        prev_q <= mem_rd_data;
      end
    end
  end

  always_comb begin
    prev_x               = {64{(SIGNED_CMP != CMP_UNSIGNED) && prev_q[DATA_W-1]}};
    prev_x[DATA_W-1:0]   = prev_q;
    cur_x                = {64{(SIGNED_CMP != CMP_UNSIGNED) && mem_rd_data[DATA_W-1]}};
    cur_x[DATA_W-1:0]    = mem_rd_data;
  end

  assign inc_exp = vld_q && (mem_rd_data != exp_rd_data);
  assign inc_ord = ord_q && order_violation(prev_x, cur_x,
                                            ORDER_DESC != ORDER_ASC,
                                            SIGNED_CMP != CMP_UNSIGNED);

  sat_counter #(.W(CNT_W)) u_cnt_unsorted (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .inc   (inc_ord),
    .q     (err_unsorted)
  );

  sat_counter #(.W(CNT_W)) u_cnt_exp (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .inc   (inc_exp),
    .q     (err_exp)
  );

  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = rd_addr_q;
  assign exp_rd_addr = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = done_q && (err_unsorted == '0) && (err_exp == '0);

endmodule

// File: tb/tb_sorted_region_checker.sv
// tb/tb_sorted_region_checker.sv - self-checking bench for sorted_region_checker
module tb_sorted_region_checker;

  localparam int NI = 5;
  // Instances: 0 desc/unsigned, 1 asc/unsigned, 2 desc/signed, 3 COUNT=8 CNT_W=2, 4 COUNT=1
  localparam logic [4:0][3:0] P_COUNT = {4'd1, 4'd8, 4'd4, 4'd4, 4'd4};
  localparam logic [4:0]      P_DESC  = 5'b11101;
  localparam logic [4:0]      P_SIGN  = 5'b00100;
  localparam logic [4:0][3:0] P_CNTW  = {4'd9, 4'd2, 4'd9, 4'd9, 4'd9};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0]       start_v;
  logic [4:0][31:0] pc_v;
  logic [4:0]       busy_v, done_v, pass_v, rden_v;
  logic [4:0][9:0]  addr_v;
  logic [4:0][6:0]  ea_v;
  logic [4:0][8:0]  eu_v, ee_v;
  logic [31:0]      mem  [NI][8];
  logic [31:0]      expv [NI][8];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int CNT = int'(P_COUNT[g]);
    localparam int CW  = int'(P_CNTW[g]);
    localparam int EW  = (CNT > 1) ? $clog2(CNT) : 1;
    logic [EW-1:0] ea;
    logic [CW-1:0] u, x;
    logic [31:0]   rd, xd;
    logic          b, d, p, re;
    logic [9:0]    a;

    sorted_region_checker #(
      .DATA_W(32), .ADDR_W(10), .BASE_IDX(32), .COUNT(CNT),
      .ORDER_DESC(int'(P_DESC[g])), .SIGNED_CMP(int'(P_SIGN[g])),
      .PC_W(32), .END_PC(32'h78), .CNT_W(CW)
    ) dut (
      .clk(clk), .reset(reset), .pc(pc_v[g]), .start(start_v[g]),
      .mem_rd_en(re), .mem_rd_addr(a), .mem_rd_data(rd),
      .exp_rd_addr(ea), .exp_rd_data(xd),
      .busy(b), .done(d), .err_unsorted(u), .err_exp(x), .pass(p)
    );

    assign busy_v[g] = b;
    assign done_v[g] = d;
    assign pass_v[g] = p;
    assign rden_v[g] = re;
    assign addr_v[g] = a;
    assign ea_v[g]   = 7'(ea);
    assign eu_v[g]   = 9'(u);
    assign ee_v[g]   = 9'(x);

    always @(posedge clk) begin
      rd <= mem[g][3'(a - 10'd32)];
      xd <= expv[g][3'(ea)];
    end
  end

  typedef struct {
    int               g;
    logic [3:0][31:0] m;
    logic [3:0][31:0] e;
    int               uns;
    int               mis;
    logic             ps;
  } vec_t;

  vec_t tv [8];

  function automatic logic [3:0][31:0] w4(input logic [31:0] a0, input logic [31:0] a1,
                                          input logic [31:0] a2, input logic [31:0] a3);
    logic [3:0][31:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'd2;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h8000_0000;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  // Reference: count out-of-order neighbours and mismatches as plain integers, then clip.
  function automatic void ref_model(input int g, output int uns, output int mis);
    int     cnt;
    int     top;
    longint a, b;
    cnt = int'(P_COUNT[g]);
    top = (1 << int'(P_CNTW[g])) - 1;
    uns = 0;
    mis = 0;
    for (int i = 0; i < cnt; i++) if (mem[g][i] != expv[g][i]) mis++;
    for (int i = 1; i < cnt; i++) begin
      if (P_SIGN[g]) begin
        a = $signed(mem[g][i-1]);
        b = $signed(mem[g][i]);
      end else begin
        a = mem[g][i-1];
        b = mem[g][i];
      end
      if (P_DESC[g] ? (a < b) : (a > b)) uns++;
    end
    if (uns > top) uns = top;
    if (mis > top) mis = top;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic run_scan(input int g, output int lat);
    int lim;
    lim = int'(P_COUNT[g]) + 20;
    start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
    lat = 1;
    while (!done_v[g] && lat < lim) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic load4(input int g, input logic [3:0][31:0] m, input logic [3:0][31:0] e);
    for (int i = 0; i < 4; i++) begin
      mem[g][i]  = m[i];
      expv[g][i] = e[i];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   g, lat, eu_m, ee_m, rises_d, rises_b, stuck;
    logic pd, pb;

    reset   = 1'b1;
    start_v = '0;
    pc_v    = '0;
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 8; i++) begin
        mem[k][i]  = '0;
        expv[k][i] = '0;
      end

    tv[0] = '{0, w4(9, 7, 7, 1), w4(9, 7, 7, 1), 0, 0, 1'b1};
    tv[1] = '{0, w4(1, 2, 3, 4), w4(9, 7, 7, 1), 3, 4, 1'b0};
    tv[2] = '{1, w4(1, 2, 3, 4), w4(9, 7, 7, 1), 0, 4, 1'b0};
    tv[3] = '{0, w4(5, 0, 32'hFFFF_FFFF, 32'h8000_0000),
                 w4(5, 0, 32'hFFFF_FFFF, 32'h8000_0000), 1, 0, 1'b0};
    tv[4] = '{2, w4(5, 0, 32'hFFFF_FFFF, 32'h8000_0000),
                 w4(5, 0, 32'hFFFF_FFFF, 32'h8000_0000), 0, 0, 1'b1};
    tv[5] = '{4, w4(5, 0, 0, 0), w4(6, 0, 0, 0), 0, 1, 1'b0};
    tv[6] = '{1, w4(1, 1, 2, 2), w4(1, 1, 2, 2), 0, 0, 1'b1};
    tv[7] = '{2, w4(7, 7, 7, 7), w4(7, 7, 7, 8), 0, 1, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_busy", busy_v, 0);
    chk("reset_done", done_v, 0);
    chk("reset_pass", pass_v, 0);
    chk("reset_rden", rden_v, 0);
    chk("reset_addr", addr_v, 0);
    chk("reset_expaddr", ea_v, 0);
    chk("reset_unsorted", eu_v, 0);
    chk("reset_experr", ee_v, 0);
    reset = 1'b0;
    @(negedge clk);

    // Issue timing on instance 0
    load4(0, w4(9, 7, 7, 1), w4(9, 7, 7, 1));
    start_v[0] = 1'b1;
    for (int l = 1; l <= 6; l++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
      if (l <= 4) begin
        chk($sformatf("tim_rden_t%0d", l), rden_v[0], 1);
        chk($sformatf("tim_addr_t%0d", l), addr_v[0], 31 + l);
        chk($sformatf("tim_expaddr_t%0d", l), ea_v[0], l - 1);
        chk($sformatf("tim_busy_t%0d", l), busy_v[0], 1);
      end else if (l == 5) begin
        chk("tim_drain_rden", rden_v[0], 0);
        chk("tim_drain_busy", busy_v[0], 1);
        chk("tim_drain_done", done_v[0], 0);
      end else begin
        chk("tim_done", done_v[0], 1);
        chk("tim_done_busy", busy_v[0], 0);
        chk("tim_done_pass", pass_v[0], 1);
      end
    end

    for (int k = 0; k < 8; k++) begin
      g = tv[k].g;
      load4(g, tv[k].m, tv[k].e);
      run_scan(g, lat);
      chk($sformatf("vec%0d_latency", k), lat, int'(P_COUNT[g]) + 2);
      chk($sformatf("vec%0d_unsorted", k), eu_v[g], tv[k].uns);
      chk($sformatf("vec%0d_experr", k), ee_v[g], tv[k].mis);
      chk($sformatf("vec%0d_pass", k), pass_v[g], tv[k].ps);
    end

    // End-PC trigger: held PC fires once, re-arm clears counters
    load4(0, w4(1, 2, 3, 4), w4(9, 7, 7, 1));
    pc_v[0] = 32'h74;
    repeat (3) @(negedge clk);
    pc_v[0] = 32'h78;
    rises_d = 0;
    rises_b = 0;
    pd = done_v[0];
    pb = busy_v[0];
    repeat (200) begin
      @(negedge clk);
      if (done_v[0] && !pd) rises_d++;
      if (busy_v[0] && !pb) rises_b++;
      pd = done_v[0];
      pb = busy_v[0];
    end
    chk("pc_done_rises", rises_d, 1);
    chk("pc_busy_rises", rises_b, 1);
    chk("pc_unsorted", eu_v[0], 3);
    chk("pc_experr", ee_v[0], 4);
    load4(0, w4(9, 7, 7, 1), w4(9, 7, 7, 1));
    pc_v[0] = 32'h0;
    repeat (3) @(negedge clk);
    pc_v[0] = 32'h78;
    @(negedge clk);
    chk("pc2_busy", busy_v[0], 1);
    chk("pc2_done_cleared", done_v[0], 0);
    chk("pc2_unsorted_cleared", eu_v[0], 0);
    chk("pc2_experr_cleared", ee_v[0], 0);
    lat = 1;
    while (!done_v[0] && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("pc2_latency", lat, 6);
    chk("pc2_pass", pass_v[0], 1);
    pc_v[0] = 32'h0;
    @(negedge clk);

    // Asynchronous reset during the third read
    load4(0, w4(1, 2, 3, 4), w4(9, 7, 7, 1));
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rden", rden_v[0], 1);
    chk("mid_addr", addr_v[0], 34);
    chk("mid_experr", ee_v[0], 1);
    #1 reset = 1'b1;
    #1;
    chk("arst_busy", busy_v[0], 0);
    chk("arst_rden", rden_v[0], 0);
    chk("arst_unsorted", eu_v[0], 0);
    chk("arst_experr", ee_v[0], 0);
    chk("arst_addr", addr_v[0], 0);
    @(negedge clk);
    reset = 1'b0;
    stuck = 0;
    repeat (50) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) stuck++;
    end
    chk("post_reset_idle_cycles", stuck, 0);

    // Saturation and ignored mid-scan trigger on instance 3
    for (int i = 0; i < 8; i++) begin
      mem[3][i]  = 32'(8 - i);
      expv[3][i] = 32'd100;
    end
    start_v[3] = 1'b1;
    @(negedge clk);
    start_v[3] = 1'b0;
    lat = 1;
    repeat (2) begin
      @(negedge clk);
      lat++;
    end
    start_v[3] = 1'b1;
    @(negedge clk);
    lat++;
    start_v[3] = 1'b0;
    while (!done_v[3] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("sat_latency", lat, 10);
    chk("sat_experr", ee_v[3], 3);
    chk("sat_unsorted", eu_v[3], 0);
    chk("sat_pass", pass_v[3], 0);
    repeat (3) @(negedge clk);
    chk("sat_no_restart_busy", busy_v[3], 0);
    chk("sat_done_held", done_v[3], 1);

    // Randomized scans against the reference model
    for (int r = 0; r < 60; r++) begin
      g = r % 3;
      for (int i = 0; i < 4; i++) begin
        mem[g][i]  = pick();
        expv[g][i] = ($urandom_range(0, 3) == 0) ? pick() : mem[g][i];
      end
      ref_model(g, eu_m, ee_m);
      run_scan(g, lat);
      chk($sformatf("rnd%0d_latency", r), lat, 6);
      chk($sformatf("rnd%0d_unsorted", r), eu_v[g], eu_m);
      chk($sformatf("rnd%0d_experr", r), ee_v[g], ee_m);
      chk($sformatf("rnd%0d_pass", r), pass_v[g], (eu_m == 0) && (ee_m == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
